// File: rtl/mon_initiator.sv
`default_nettype none
// ============================================================================
// mon_initiator : host-side LOAD/DUMP/EXEC initiator for the monitor serial link
// Revision      : 1.0
// ============================================================================
module mon_initiator #(
   parameter logic [23:0] TIMEOUT = 24'd1200000,
   parameter logic [15:0] TXGAP   = 16'hfff
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  cmd,
   input  logic [15:0] addr,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   input  logic [7:0]  pl_data,
   input  logic        pl_empty,
   output logic        pl_read,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic [7:0]  tx_byte,
   output logic        transmit,
   input  logic        is_transmitting,
   input  logic [7:0]  rx_byte,
   input  logic        received
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GAP     = 3'd1,
      S_TX      = 3'd2,
      S_ECHO    = 3'd3,
      S_PL_WAIT = 3'd4,
      S_DRX     = 3'd5
   } state_t;

   localparam logic [1:0] c_cmd_load     = 2'd1;
   localparam logic [1:0] c_cmd_dump     = 2'd2;
   localparam logic [1:0] c_err_cmd      = 2'd1;
   localparam logic [1:0] c_err_echo     = 2'd2;
   localparam logic [1:0] c_err_timeout  = 2'd3;
   localparam logic [2:0] c_idx_last_hdr = 3'd5;
   localparam logic [2:0] c_idx_payload  = 3'd6;

   state_t      state_q, state_d;
   logic [1:0]  cmd_q, cmd_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] len_q, len_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] gap_q, gap_d;
   logic [23:0] tmo_q, tmo_d;
   logic [7:0]  pl_byte_q, pl_byte_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        pl_read_q, pl_read_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        transmit_q, transmit_d;

   logic [7:0]  w_hdr_byte;
   logic        w_tmo_expire;

   always_comb begin
      case (idx_q)
         3'd0:    w_hdr_byte = {6'd0, cmd_q};
         3'd1:    w_hdr_byte = 8'h00;
         3'd2:    w_hdr_byte = addr_q[15:8];
         3'd3:    w_hdr_byte = addr_q[7:0];
         3'd4:    w_hdr_byte = len_q[15:8];
         default: w_hdr_byte = len_q[7:0];
      endcase
   end

   // The counter is one cycle from zero: this quiet cycle is the last allowed.
   assign w_tmo_expire = (tmo_q <= 24'd1);

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      len_d      = len_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      tmo_d      = tmo_q;
      pl_byte_d  = pl_byte_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = err_code_q;
      pl_read_d  = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      tx_byte_d  = tx_byte_q;
      transmit_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cmd == 2'd0) begin
                  error_d    = 1'b1;
                  err_code_d = c_err_cmd;
               end else begin
                  cmd_d      = cmd;
                  addr_d     = addr;
                  len_d      = len;
                  idx_d      = 3'd0;
                  gap_d      = TXGAP;
                  busy_d     = 1'b1;
                  err_code_d = 2'd0;
                  state_d    = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == 16'd0) state_d = S_TX;
            else                gap_d   = gap_q - 16'd1;
         end
         S_TX: begin
            if (!is_transmitting) begin
               tx_byte_d  = (idx_q == c_idx_payload) ? pl_byte_q : w_hdr_byte;
               transmit_d = 1'b1;
               tmo_d      = TIMEOUT;
               state_d    = S_ECHO;
            end
         end
         S_ECHO: begin
            if (received) begin
               if (rx_byte != tx_byte_q) begin
                  error_d    = 1'b1;
                  err_code_d = c_err_echo;
                  busy_d     = 1'b0;
                  state_d    = S_IDLE;
               end else if (idx_q < c_idx_last_hdr) begin
                  idx_d   = idx_q + 3'd1;
                  gap_d   = TXGAP;
                  state_d = S_GAP;
               end else if (idx_q == c_idx_last_hdr) begin
                  if (cmd_q == c_cmd_load && len_q != 16'd0) begin
                     idx_d   = c_idx_payload;
                     state_d = S_PL_WAIT;
                  end else if (cmd_q == c_cmd_dump && len_q != 16'd0) begin
                     tmo_d   = TIMEOUT;
                     state_d = S_DRX;
                  end else begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end else begin
                  len_d = len_q - 16'd1;
                  if (len_q == 16'd1) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_PL_WAIT;
                  end
               end
            end else if (w_tmo_expire) begin
               error_d    = 1'b1;
               err_code_d = c_err_timeout;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end else begin
               tmo_d = tmo_q - 24'd1;
            end
         end
         S_PL_WAIT: begin
            if (!pl_empty) begin
               pl_byte_d = pl_data;
               pl_read_d = 1'b1;
               gap_d     = TXGAP;
               state_d   = S_GAP;
            end
         end
         S_DRX: begin
            if (received) begin
               rd_data_d  = rx_byte;
               rd_valid_d = 1'b1;
               len_d      = len_q - 16'd1;
               tmo_d      = TIMEOUT;
               if (len_q == 16'd1) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else if (w_tmo_expire) begin
               error_d    = 1'b1;
               err_code_d = c_err_timeout;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end else begin
               tmo_d = tmo_q - 24'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= 2'd0;
         addr_q     <= 16'd0;
         len_q      <= 16'd0;
         idx_q      <= 3'd0;
         gap_q      <= 16'd0;
         tmo_q      <= 24'd0;
         pl_byte_q  <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'd0;
         pl_read_q  <= 1'b0;
         rd_data_q  <= 8'd0;
         rd_valid_q <= 1'b0;
         tx_byte_q  <= 8'd0;
         transmit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         tmo_q      <= tmo_d;
         pl_byte_q  <= pl_byte_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         pl_read_q  <= pl_read_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         tx_byte_q  <= tx_byte_d;
         transmit_q <= transmit_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign err_code = err_code_q;
   assign pl_read  = pl_read_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign tx_byte  = tx_byte_q;
   assign transmit = transmit_q;

endmodule
`default_nettype wire

// File: tb/tb_mon_initiator.sv
`default_nettype none
// ============================================================================
// tb_mon_initiator : scoreboard bench with a loopback/responder uart model
// Revision         : 1.0
// ============================================================================
module tb_mon_initiator;

   localparam logic [23:0] TB_TIMEOUT = 24'd100;
   localparam logic [15:0] TB_TXGAP   = 16'd4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  cmd;
   logic [15:0] addr;
   logic [15:0] len;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [7:0]  pl_data;
   logic        pl_empty;
   logic        pl_read;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [7:0]  tx_byte;
   logic        transmit;
   logic        is_transmitting;
   logic [7:0]  rx_byte;
   logic        received;

   always #5 clk = ~clk;

   mon_initiator #(.TIMEOUT(TB_TIMEOUT), .TXGAP(TB_TXGAP)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .addr(addr), .len(len),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .pl_data(pl_data), .pl_empty(pl_empty), .pl_read(pl_read),
      .rd_data(rd_data), .rd_valid(rd_valid), .tx_byte(tx_byte), .transmit(transmit),
      .is_transmitting(is_transmitting), .rx_byte(rx_byte), .received(received)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ev_cnt = 0;
   int pl_cnt = 0;
   int rd_cnt = 0;
   int last_rd_cyc = 0;
   int tx_cnt = 0;
   int tx_base = 0;
   int corrupt_n = 0;
   int dump_n = 0;
   logic [7:0] dump_v [0:3];
   logic [7:0] exp_tx [$];
   logic [7:0] exp_rd [$];
   int         exp_ev [$];   // 0 = done, 1..3 = error with that err_code
   logic [7:0] pl_src [$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   task automatic push_tx(input logic [71:0] v, input int n);
      for (int i = 0; i < n; i++) exp_tx.push_back(v[8*(n-1-i) +: 8]);
   endtask

   task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [15:0] l);
      @(negedge clk);
      tx_base = tx_cnt;
      cmd = c; addr = a; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cmd = 2'd2; addr = 16'hDEAD; len = 16'hBEEF;
   endtask

   task automatic wait_ev(input int target, input string name);
      int n = 0;
      while (ev_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (ev_cnt < target) flag({name, " completion never seen"});
   endtask

   // Scoreboard monitor: compares every DUT output event against the queues.
   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (transmit) begin
            if (exp_tx.size() == 0) flag("unexpected transmit");
            else check("tx byte", int'(tx_byte), int'(exp_tx.pop_front()));
         end
         if (rd_valid) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (exp_rd.size() == 0) flag("unexpected rd_valid");
            else check("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
         end
         if (pl_read) pl_cnt++;
         if (done && error) flag("done and error together");
         if (done || error) begin
            ev_cnt++;
            check("busy low at completion", int'(busy), 0);
            if (exp_ev.size() == 0) flag("unexpected completion");
            else check("completion code", done ? 0 : int'(err_code), exp_ev.pop_front());
            if (error && err_code == 2'd3)
               check("timeout latency", cyc - last_rd_cyc, 100);
         end
      end
   end

   initial begin : payload_source
      pl_empty = 1'b1;
      pl_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (pl_read && pl_src.size() > 0) pl_src.delete(0);
         pl_empty = (pl_src.size() == 0);
         pl_data  = pl_empty ? 8'h00 : pl_src[0];
      end
   end

   // Loopback uart: echoes each byte, optionally corrupts one, and can return DUMP data.
   initial begin : uart_model
      logic [7:0] b;
      int idx;
      is_transmitting = 1'b0;
      received = 1'b0;
      rx_byte = 8'h00;
      forever begin
         @(negedge clk);
         if (transmit) begin
            b = tx_byte;
            tx_cnt++;
            idx = tx_cnt - tx_base;
            is_transmitting = 1'b1;
            repeat (8) @(negedge clk);
            is_transmitting = 1'b0;
            rx_byte = (idx == corrupt_n) ? 8'h01 : b;
            received = 1'b1;
            @(negedge clk);
            received = 1'b0;
            if (idx == 6) begin
               for (int i = 0; i < dump_n; i++) begin
                  repeat (6) @(negedge clk);
                  rx_byte = dump_v[i];
                  received = 1'b1;
                  @(negedge clk);
                  received = 1'b0;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      int e0, p0, r0, n;
      reset_n = 1'b0; start = 1'b0; cmd = 2'd0; addr = 16'd0; len = 16'd0;
      repeat (3) @(negedge clk);
      check("reset outputs", int'({busy, done, error, err_code, pl_read, rd_valid,
                                   rd_data, tx_byte, transmit}), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // LOAD 0x0010 len 3 with payload A5 5A 3C
      pl_src = '{8'hA5, 8'h5A, 8'h3C};
      push_tx(72'h01_00_00_10_00_03_A5_5A_3C, 9);
      exp_ev.push_back(0);
      e0 = ev_cnt; p0 = pl_cnt;
      issue(2'd1, 16'h0010, 16'd3);
      check("busy after start", int'(busy), 1);
      wait_ev(e0 + 1, "load");
      check("load pl_read pulses", pl_cnt - p0, 3);
      check("load tx drained", exp_tx.size(), 0);
      repeat (20) @(negedge clk);

      // DUMP 0x0100 len 2, responder returns 11 22
      dump_v[0] = 8'h11; dump_v[1] = 8'h22; dump_n = 2;
      push_tx(72'h02_00_01_00_00_02, 6);
      exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
      exp_ev.push_back(0);
      e0 = ev_cnt; r0 = rd_cnt;
      issue(2'd2, 16'h0100, 16'd2);
      wait_ev(e0 + 1, "dump");
      check("dump rd_valid pulses", rd_cnt - r0, 2);
      dump_n = 0;
      repeat (20) @(negedge clk);

      // EXEC with word 0x1234
      push_tx(72'h03_00_00_00_12_34, 6);
      exp_ev.push_back(0);
      e0 = ev_cnt; p0 = pl_cnt; r0 = rd_cnt;
      issue(2'd3, 16'h0000, 16'h1234);
      wait_ev(e0 + 1, "exec");
      check("exec pl_read pulses", pl_cnt - p0, 0);
      check("exec rd_valid pulses", rd_cnt - r0, 0);
      check("exec tx drained", exp_tx.size(), 0);
      repeat (20) @(negedge clk);

      // LOAD len 2 with the 3rd header echo corrupted
      corrupt_n = 3;
      push_tx(72'h01_00_00, 3);
      exp_ev.push_back(2);
      e0 = ev_cnt;
      issue(2'd1, 16'h0020, 16'd2);
      wait_ev(e0 + 1, "echo mismatch");
      check("mismatch busy", int'(busy), 0);
      repeat (50) @(negedge clk);
      check("mismatch err_code held", int'(err_code), 2);
      check("mismatch tx drained", exp_tx.size(), 0);
      corrupt_n = 0;

      // DUMP len 4, responder stops after 2 bytes
      dump_v[0] = 8'h33; dump_v[1] = 8'h44; dump_n = 2;
      push_tx(72'h02_00_02_00_00_04, 6);
      exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
      exp_ev.push_back(3);
      e0 = ev_cnt; r0 = rd_cnt;
      issue(2'd2, 16'h0200, 16'd4);
      wait_ev(e0 + 1, "dump timeout");
      check("timeout rd_valid pulses", rd_cnt - r0, 2);
      check("timeout err_code", int'(err_code), 3);
      dump_n = 0;
      repeat (20) @(negedge clk);

      // Illegal command 0
      exp_ev.push_back(1);
      @(negedge clk);
      tx_base = tx_cnt;
      cmd = 2'd0; addr = 16'h1111; len = 16'h0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("bad cmd error next cycle", int'(error), 1);
      check("bad cmd err_code", int'(err_code), 1);
      check("bad cmd busy", int'(busy), 0);
      repeat (30) @(negedge clk);
      check("bad cmd no transmit", tx_cnt - tx_base, 0);

      // Reset asserted part way through a LOAD header
      push_tx(72'h01_00_00, 3);
      issue(2'd1, 16'h0040, 16'd3);
      n = 0;
      while (tx_cnt - tx_base < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (tx_cnt - tx_base < 3) flag("reset test header never sent");
      #2 reset_n = 1'b0;
      #1 check("async reset outputs", int'({busy, done, error, err_code, pl_read, rd_valid,
                                            rd_data, tx_byte, transmit}), 0);
      repeat (30) @(negedge clk);
      reset_n = 1'b1;
      check("reset tx drained", exp_tx.size(), 0);
      repeat (5) @(negedge clk);

      // LOAD len 0 after reset: header only
      push_tx(72'h01_00_00_30_00_00, 6);
      exp_ev.push_back(0);
      e0 = ev_cnt; p0 = pl_cnt;
      issue(2'd1, 16'h0030, 16'd0);
      wait_ev(e0 + 1, "load len0");
      check("len0 pl_read pulses", pl_cnt - p0, 0);
      repeat (20) @(negedge clk);

      check("final tx queue", exp_tx.size(), 0);
      check("final rd queue", exp_rd.size(), 0);
      check("final event queue", exp_ev.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
